// File: rtl/mem_port_arbiter.sv
// mem_port_arbiter
//   Shares one single-beat memory port between the multicycle core and a
//   loader/debug master. Grants are combinational (req/gnt handshake). Reads
//   return MEM_LAT cycles after grant, and the next grant is allowed in the
//   same cycle as the return. Writes complete in their grant cycle.
//
//   Build option: define MEM_ARB_RR_EN for round-robin arbitration on ties.
//   Without it, the core has fixed priority. A burst counter bounds loader
//   starvation to MAX_BURST consecutive core grants.
//
// Ports
//   clk, reset                          clock, synchronous active-high reset
//   core_req/we/addr/wdata              core request (held until core_gnt)
//   core_gnt, core_rvalid, core_rdata   core grant, read-return pulse, data
//   ldr_req/we/addr/wdata               loader request (held until ldr_gnt)
//   ldr_gnt, ldr_rvalid, ldr_rdata      loader grant, read-return pulse, data
//   mem_addr/we/wdata                   memory command (zero when no grant)
//   mem_rdata                           memory read data
module mem_port_arbiter #(
    parameter int ADDR_W    = 32,
    parameter int DATA_W    = 32,
    parameter int MEM_LAT   = 1,
    parameter int MAX_BURST = 8
) (
    input  logic              clk,
    input  logic              reset,
    input  logic              core_req,
    input  logic              core_we,
    input  logic [ADDR_W-1:0] core_addr,
    input  logic [DATA_W-1:0] core_wdata,
    output logic              core_gnt,
    output logic              core_rvalid,
    output logic [DATA_W-1:0] core_rdata,
    input  logic              ldr_req,
    input  logic              ldr_we,
    input  logic [ADDR_W-1:0] ldr_addr,
    input  logic [DATA_W-1:0] ldr_wdata,
    output logic              ldr_gnt,
    output logic              ldr_rvalid,
    output logic [DATA_W-1:0] ldr_rdata,
    output logic [ADDR_W-1:0] mem_addr,
    output logic              mem_we,
    output logic [DATA_W-1:0] mem_wdata,
    input  logic [DATA_W-1:0] mem_rdata
);
    localparam int LAT_W = (MEM_LAT < 2) ? 1 : $clog2(MEM_LAT + 1);

    typedef enum logic {IDLE, RD_WAIT} state_t;

    state_t           state, state_nxt;
    logic [LAT_W-1:0] lat_cnt, lat_cnt_nxt;
    logic             owner, owner_nxt;   // 0 = core, 1 = loader
    logic             lat_done;
    logic             arb_en;
    logic             pick_ldr;           // tie-break result when both request

    // The last wait cycle doubles as an arbitration cycle for back-to-back reads.
    assign lat_done = (state == RD_WAIT) && (lat_cnt == LAT_W'(MEM_LAT));
    assign arb_en   = !reset && ((state == IDLE) || lat_done);

    assign core_rdata  = mem_rdata;
    assign ldr_rdata   = mem_rdata;
    // Gated by reset so that an outstanding read is dropped silently.
    assign core_rvalid = !reset && lat_done && (owner == 1'b0);
    assign ldr_rvalid  = !reset && lat_done && (owner == 1'b1);

`ifdef MEM_ARB_RR_EN
    logic last_owner;

    // Starts as loader so the core wins the first tie.
    assign pick_ldr = (last_owner == 1'b0);

    always_ff @(posedge clk) begin
        if (reset)
            last_owner <= 1'b1;
        else if (core_gnt || ldr_gnt)
            last_owner <= ldr_gnt;
    end
`else
    localparam int BURST_W = (MAX_BURST < 2) ? 1 : $clog2(MAX_BURST + 1);

    logic [BURST_W-1:0] burst_cnt;

    assign pick_ldr = (burst_cnt == BURST_W'(MAX_BURST));

    // Counts core grants taken while the loader waits; never exceeds MAX_BURST
    // because the loader wins every tie once the bound is reached.
    always_ff @(posedge clk) begin
        if (reset)
            burst_cnt <= '0;
        else if (!ldr_req || ldr_gnt)
            burst_cnt <= '0;
        else if (core_gnt && !pick_ldr)
            burst_cnt <= burst_cnt + 1'b1;
    end
`endif

    always_ff @(posedge clk) begin
        if (reset) begin
            state   <= IDLE;
            lat_cnt <= '0;
            owner   <= 1'b0;
        end else begin
            state   <= state_nxt;
            lat_cnt <= lat_cnt_nxt;
            owner   <= owner_nxt;
        end
    end

    always_comb begin
        core_gnt    = 1'b0;
        ldr_gnt     = 1'b0;
        mem_addr    = '0;
        mem_we      = 1'b0;
        mem_wdata   = '0;
        state_nxt   = state;
        lat_cnt_nxt = lat_cnt;
        owner_nxt   = owner;

        if (arb_en) begin
            if (core_req && ldr_req) begin
                ldr_gnt  = pick_ldr;
                core_gnt = !pick_ldr;
            end else begin
                core_gnt = core_req;
                ldr_gnt  = ldr_req;
            end
        end

        if (core_gnt) begin
            mem_addr  = core_addr;
            mem_we    = core_we;
            mem_wdata = core_wdata;
        end else if (ldr_gnt) begin
            mem_addr  = ldr_addr;
            mem_we    = ldr_we;
            mem_wdata = ldr_wdata;
        end

        if (state == RD_WAIT && !lat_done) begin
            lat_cnt_nxt = lat_cnt + 1'b1;
        end else begin
            state_nxt = IDLE;
            if ((core_gnt || ldr_gnt) && !mem_we) begin
                state_nxt   = RD_WAIT;
                lat_cnt_nxt = LAT_W'(1);
                owner_nxt   = ldr_gnt;
            end
        end
    end
endmodule

// File: tb/tb_mem_port_arbiter.sv
// tb_mem_port_arbiter
//   Two arbiter instances (MEM_LAT = 1 and MEM_LAT = 3) share clock and reset
//   but have independent requesters and memories. A cycle-indexed reference
//   model (outstanding read due-cycle, shadow memory, tie-break rule) predicts
//   every output on every cycle. Directed scenarios come first, followed by a
//   randomized phase.
module tb_mem_port_arbiter;
    localparam int MAX_BURST = 8;

    logic        clk = 1'b0;
    logic        reset;
    logic        core_req [2];
    logic        core_we [2];
    logic [31:0] core_addr [2];
    logic [31:0] core_wdata [2];
    logic        core_gnt [2];
    logic        core_rvalid [2];
    logic [31:0] core_rdata [2];
    logic        ldr_req [2];
    logic        ldr_we [2];
    logic [31:0] ldr_addr [2];
    logic [31:0] ldr_wdata [2];
    logic        ldr_gnt [2];
    logic        ldr_rvalid [2];
    logic [31:0] ldr_rdata [2];
    logic [31:0] mem_addr [2];
    logic        mem_we [2];
    logic [31:0] mem_wdata [2];
    logic [31:0] mem_rdata [2];

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    int mode = 0;   // 0: drop after grant, 1: continuous writes, 2: random

    // Reference model state
    bit          outst [2];
    int          due [2];
    bit          rd_own [2];
    logic [31:0] rd_dat [2];
    int          burst [2];
    bit          last [2];
    logic [31:0] shadow [2][16];
    bit          gc [2];
    bit          gl [2];

    // Observations used by scenario checks
    int          c_gnt_cyc [2];
    int          l_gnt_cyc [2];
    int          c_rv_cyc [2];
    int          l_rv_cyc [2];
    int          lgnt_cnt [2];
    int          lrv_cnt [2];
    logic [31:0] c_rdata_last [2];

    always #5 clk = ~clk;

    function automatic logic [31:0] init_word(input int k);
        return (k == 4) ? 32'hDEADBEEF : (32'hA5A50000 + 32'(k));
    endfunction

    function automatic int lat_of(input int i);
        return (i == 0) ? 1 : 3;
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_inst
        localparam int LAT = (g == 0) ? 1 : 3;
        logic [31:0] mem [16];
        logic [31:0] pipe [LAT];

        initial for (int k = 0; k < 16; k++) mem[k] = init_word(k);

        always @(posedge clk) begin
            if (mem_we[g]) mem[mem_addr[g][5:2]] <= mem_wdata[g];
            pipe[0] <= mem[mem_addr[g][5:2]];
            for (int k = 1; k < LAT; k++) pipe[k] <= pipe[k-1];
        end
        assign mem_rdata[g] = pipe[LAT-1];

        mem_port_arbiter #(.ADDR_W(32), .DATA_W(32), .MEM_LAT(LAT), .MAX_BURST(MAX_BURST)) u_dut (
            .clk(clk), .reset(reset),
            .core_req(core_req[g]), .core_we(core_we[g]), .core_addr(core_addr[g]),
            .core_wdata(core_wdata[g]), .core_gnt(core_gnt[g]), .core_rvalid(core_rvalid[g]),
            .core_rdata(core_rdata[g]),
            .ldr_req(ldr_req[g]), .ldr_we(ldr_we[g]), .ldr_addr(ldr_addr[g]),
            .ldr_wdata(ldr_wdata[g]), .ldr_gnt(ldr_gnt[g]), .ldr_rvalid(ldr_rvalid[g]),
            .ldr_rdata(ldr_rdata[g]),
            .mem_addr(mem_addr[g]), .mem_we(mem_we[g]), .mem_wdata(mem_wdata[g]),
            .mem_rdata(mem_rdata[g])
        );
    end

    task automatic chk(input string tag, input int i, input logic [63:0] obs, input logic [63:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s[lat%0d] cyc=%0d observed=%0h expected=%0h", tag, lat_of(i), cyc, obs, exp);
        end
    endtask

    task automatic model_check(input int i);
        bit          due_now, allow, wc, wl, ewe;
        logic [31:0] ea, ed;
        due_now = outst[i] && (due[i] == cyc);
        wc = 1'b0;
        wl = 1'b0;
        if (reset) begin
            chk("rst_core_gnt", i, 64'(core_gnt[i]), 64'd0);
            chk("rst_ldr_gnt", i, 64'(ldr_gnt[i]), 64'd0);
            chk("rst_rvalid", i, 64'({core_rvalid[i], ldr_rvalid[i]}), 64'd0);
            chk("rst_mem_we", i, 64'(mem_we[i]), 64'd0);
            chk("rst_mem_addr", i, 64'(mem_addr[i]), 64'd0);
            outst[i] = 1'b0;
            burst[i] = 0;
            last[i]  = 1'b1;
            gc[i]    = 1'b0;
            gl[i]    = 1'b0;
            return;
        end
        allow = !outst[i] || due_now;
        if (allow) begin
            if (core_req[i] && ldr_req[i]) begin
`ifdef MEM_ARB_RR_EN
                wl = (last[i] == 1'b0);
`else
                wl = (burst[i] == MAX_BURST);
`endif
                wc = !wl;
            end else begin
                wc = core_req[i];
                wl = ldr_req[i];
            end
        end
        ea  = wc ? core_addr[i]  : (wl ? ldr_addr[i]  : 32'd0);
        ed  = wc ? core_wdata[i] : (wl ? ldr_wdata[i] : 32'd0);
        ewe = wc ? core_we[i]    : (wl ? ldr_we[i]    : 1'b0);

        chk("core_gnt", i, 64'(core_gnt[i]), 64'(wc));
        chk("ldr_gnt", i, 64'(ldr_gnt[i]), 64'(wl));
        chk("core_rvalid", i, 64'(core_rvalid[i]), 64'(due_now && !rd_own[i]));
        chk("ldr_rvalid", i, 64'(ldr_rvalid[i]), 64'(due_now && rd_own[i]));
        if (due_now && !rd_own[i]) chk("core_rdata", i, 64'(core_rdata[i]), 64'(rd_dat[i]));
        if (due_now && rd_own[i])  chk("ldr_rdata", i, 64'(ldr_rdata[i]), 64'(rd_dat[i]));
        chk("mem_addr", i, 64'(mem_addr[i]), 64'(ea));
        chk("mem_we", i, 64'(mem_we[i]), 64'(ewe));
        chk("mem_wdata", i, 64'(mem_wdata[i]), 64'(ed));

        if (due_now) outst[i] = 1'b0;
        if (wc || wl) begin
            if (!ewe) begin
                outst[i]  = 1'b1;
                due[i]    = cyc + lat_of(i);
                rd_own[i] = wl;
                rd_dat[i] = shadow[i][ea[5:2]];
            end else begin
                shadow[i][ea[5:2]] = ed;
            end
            last[i] = wl;
        end
        if (wl || !ldr_req[i]) burst[i] = 0;
        else if (wc && burst[i] < MAX_BURST) burst[i]++;
        gc[i] = wc;
        gl[i] = wl;
    endtask

    task automatic rand_req(input int i, input bit ldr, input bit wr_only);
        logic [3:0]  w;
        logic [31:0] d;
        bit          we;
        w  = 4'($urandom_range(15, 0));
        d  = $urandom;
        we = wr_only ? 1'b1 : 1'($urandom_range(1, 0));
        if (wr_only) w[3] = 1'b1;   // keep continuous writes away from the low words
        if (ldr) begin
            ldr_req[i] = 1'b1; ldr_we[i] = we; ldr_addr[i] = {26'd0, w, 2'b00}; ldr_wdata[i] = d;
        end else begin
            core_req[i] = 1'b1; core_we[i] = we; core_addr[i] = {26'd0, w, 2'b00}; core_wdata[i] = d;
        end
    endtask

    task automatic advance_req(input int i);
        case (mode)
            0: begin
                if (gc[i]) core_req[i] = 1'b0;
                if (gl[i]) ldr_req[i] = 1'b0;
            end
            1: begin
                if (gc[i]) rand_req(i, 1'b0, 1'b1);
                if (gl[i]) rand_req(i, 1'b1, 1'b1);
            end
            default: begin
                if (gc[i] || !core_req[i]) begin
                    if ($urandom_range(1, 0) == 1) rand_req(i, 1'b0, 1'b0);
                    else core_req[i] = 1'b0;
                end
                if (gl[i] || !ldr_req[i]) begin
                    if ($urandom_range(1, 0) == 1) rand_req(i, 1'b1, 1'b0);
                    else ldr_req[i] = 1'b0;
                end
            end
        endcase
    endtask

    task automatic step();
        @(negedge clk);
        for (int i = 0; i < 2; i++) begin
            if (core_gnt[i]) c_gnt_cyc[i] = cyc;
            if (ldr_gnt[i]) begin l_gnt_cyc[i] = cyc; lgnt_cnt[i]++; end
            if (core_rvalid[i]) begin c_rv_cyc[i] = cyc; c_rdata_last[i] = core_rdata[i]; end
            if (ldr_rvalid[i]) begin l_rv_cyc[i] = cyc; lrv_cnt[i]++; end
            model_check(i);
        end
        cyc++;
        @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) advance_req(i);
    endtask

    task automatic set_core(input int i, input bit rq, input bit we, input logic [31:0] a, input logic [31:0] d);
        core_req[i] = rq; core_we[i] = we; core_addr[i] = a; core_wdata[i] = d;
    endtask

    task automatic set_ldr(input int i, input bit rq, input bit we, input logic [31:0] a, input logic [31:0] d);
        ldr_req[i] = rq; ldr_we[i] = we; ldr_addr[i] = a; ldr_wdata[i] = d;
    endtask

    task automatic clear_stats();
        for (int i = 0; i < 2; i++) begin
            c_gnt_cyc[i] = -100; l_gnt_cyc[i] = -100; c_rv_cyc[i] = -100; l_rv_cyc[i] = -100;
            lgnt_cnt[i] = 0; lrv_cnt[i] = 0; c_rdata_last[i] = 32'd0;
        end
    endtask

    initial begin
        int n;
        reset = 1'b1;
        for (int i = 0; i < 2; i++) begin
            for (int k = 0; k < 16; k++) shadow[i][k] = init_word(k);
            outst[i] = 1'b0; burst[i] = 0; last[i] = 1'b1; gc[i] = 1'b0; gl[i] = 1'b0;
            set_core(i, 1'b1, 1'b0, 32'h10, 32'd0);
            set_ldr(i, 1'b1, 1'b0, 32'h20, 32'd0);
        end
        clear_stats();

        // Reset held with both requesting
        for (int s = 0; s < 3; s++) step();
        reset = 1'b0;
        for (int i = 0; i < 2; i++) set_ldr(i, 1'b0, 1'b0, 32'h0, 32'd0);

        // Single core read of 0x10
        clear_stats();
        for (int s = 0; s < 5; s++) step();
        chk("rd_latency", 0, 64'(c_rv_cyc[0] - c_gnt_cyc[0]), 64'd1);
        chk("rd_data", 0, 64'(c_rdata_last[0]), 64'hDEADBEEF);
        chk("rd_latency", 1, 64'(c_rv_cyc[1] - c_gnt_cyc[1]), 64'd3);
        chk("no_ldr_rvalid", 0, 64'(lrv_cnt[0]), 64'd0);

        // Core read with loader read pending: next grant lands on the return cycle
        clear_stats();
        for (int i = 0; i < 2; i++) begin
            set_core(i, 1'b1, 1'b0, 32'h14, 32'd0);
            set_ldr(i, 1'b1, 1'b0, 32'h20, 32'd0);
        end
        for (int s = 0; s < 8; s++) step();
`ifdef MEM_ARB_RR_EN
        chk("b2b_spacing", 1, 64'(c_gnt_cyc[1] - l_gnt_cyc[1]), 64'd3);
        chk("b2b_same_cycle", 1, 64'(l_rv_cyc[1]), 64'(c_gnt_cyc[1]));
`else
        chk("b2b_spacing", 1, 64'(l_gnt_cyc[1] - c_gnt_cyc[1]), 64'd3);
        chk("b2b_same_cycle", 1, 64'(c_rv_cyc[1]), 64'(l_gnt_cyc[1]));
`endif

        // Continuous writes from both sides
        clear_stats();
        mode = 1;
        for (int i = 0; i < 2; i++) begin
            rand_req(i, 1'b0, 1'b1);
            rand_req(i, 1'b1, 1'b1);
        end
        for (int s = 0; s < 27; s++) step();
        for (int i = 0; i < 2; i++) begin
`ifdef MEM_ARB_RR_EN
            chk("rr_ldr_grants", i, 64'(lgnt_cnt[i] == 13 || lgnt_cnt[i] == 14), 64'd1);
`else
            chk("burst_ldr_grants", i, 64'(lgnt_cnt[i]), 64'd3);
`endif
        end
        mode = 0;
        for (int s = 0; s < 4; s++) step();

        // Loader read interrupted by reset
        clear_stats();
        for (int i = 0; i < 2; i++) set_ldr(i, 1'b1, 1'b0, 32'h24, 32'd0);
        n = 0;
        while (lgnt_cnt[1] == 0 && n < 10) begin step(); n++; end
        chk("ldr_grant_timeout", 1, 64'(lgnt_cnt[1]), 64'd1);
        reset = 1'b1;
        for (int s = 0; s < 2; s++) step();
        reset = 1'b0;
        for (int s = 0; s < 4; s++) step();
        chk("rst_drops_rvalid", 0, 64'(lrv_cnt[0]), 64'd0);
        chk("rst_drops_rvalid", 1, 64'(lrv_cnt[1]), 64'd0);

        // Core read after reset
        clear_stats();
        for (int i = 0; i < 2; i++) set_core(i, 1'b1, 1'b0, 32'h10, 32'd0);
        for (int s = 0; s < 6; s++) step();
        chk("post_rst_rd", 0, 64'(c_rdata_last[0]), 64'hDEADBEEF);
        chk("post_rst_rd", 1, 64'(c_rdata_last[1]), 64'hDEADBEEF);

        // Randomized traffic
        mode = 2;
        for (int s = 0; s < 400; s++) step();
        mode = 0;
        for (int s = 0; s < 12; s++) step();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
